// File: rtl/conv_window_accumulator.sv
// Window accumulator: sums KERNEL_SIZE signed products onto a bias, saturates, hands off via valid/ready.
// Define CONV_ACC_RELU_EN to clamp negative results to zero before they are registered.
module conv_window_accumulator #(
  parameter int DATA_WIDTH  = 12,
  parameter int KERNEL_SIZE = 25,
  parameter int ACC_WIDTH   = 17,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ACCUM = 4'b0010,
    SAT   = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  logic [ACC_WIDTH-1:0]    bias_ext, data_ext;
  logic [ACC_WIDTH-DATA_WIDTH:0] acc_hi;
  logic [DATA_WIDTH-1:0]   sat_val;

  assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
  assign data_ext = {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign acc_hi   = acc_q[ACC_WIDTH-1:DATA_WIDTH-1];

  // The sum fits DATA_WIDTH only when every bit above the result sign bit matches it.
  always_comb begin
    sat_val = acc_q[DATA_WIDTH-1:0];
    if (!((&acc_hi) || (~|acc_hi))) begin
      sat_val = acc_q[ACC_WIDTH-1] ? MIN_NEG : MAX_POS;
    end
`ifdef CONV_ACC_RELU_EN
    if (sat_val[DATA_WIDTH-1]) begin
      sat_val = '0;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + data_ext;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = SAT;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      SAT: begin
        out_data_d  = sat_val;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/conv_window_accumulator.md
Name: conv_window_accumulator

Overview:
- Sits directly downstream of the fixed-point multiplier cells in the LeNet-5 convolution datapath.
- Consumes a stream of signed Q(DATA_WIDTH-FRACTIONAL_BITS).FRACTIONAL_BITS products, one per accepted beat.
- Sums exactly KERNEL_SIZE products per output pixel and adds a per-filter bias.
- Saturates the result to DATA_WIDTH and hands it to the next stage (pooling or activation) over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 12: width of the product, bias and result words. Signed, same Q format throughout.
- KERNEL_SIZE, 25: products per window (5x5). Must be at least 1.
- ACC_WIDTH, 17: internal accumulator width. Must be at least DATA_WIDTH + ceil(log2(KERNEL_SIZE+1)).
- CNT_WIDTH, 5: beat counter width. Must hold KERNEL_SIZE-1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a new window. Honoured only in IDLE.
- bias, input, DATA_WIDTH: signed bias, sampled in the cycle start is accepted.
- in_valid, input, 1: in_data holds a valid product.
- in_ready, output, 1: block accepts a product this cycle.
- in_data, input, DATA_WIDTH: signed product from the multiplier.
- out_valid, output, 1: out_data holds a valid result.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, DATA_WIDTH: saturated signed result.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; acc=0; cnt=0; in_ready=0; out_valid=0; out_data=0; busy=0.
- States are one-hot: IDLE=4'b0001, ACCUM=4'b0010, SAT=4'b0100, DONE=4'b1000.
- IDLE:
  - in_ready=0.
  - On start=1: acc <= sign-extended bias; cnt <= 0; next state ACCUM.
- ACCUM:
  - in_ready=1 (combinational from state).
  - Each in_valid&&in_ready beat: acc <= acc + sign-extended in_data; cnt <= cnt+1.
  - On the beat accepted with cnt==KERNEL_SIZE-1: next state SAT; cnt <= 0.
  - in_valid=0 cycles are stalls. acc and cnt hold, with no timeout.
- SAT (one cycle, in_ready=0):
  - If acc > 2^(DATA_WIDTH-1)-1, out_data <= max positive.
  - If acc < -2^(DATA_WIDTH-1), out_data <= min negative.
  - Otherwise out_data <= acc[DATA_WIDTH-1:0].
  - out_valid <= 1; next state DONE.
- DONE:
  - out_valid and out_data are held stable while out_ready=0.
  - On out_ready=1: out_valid <= 0; next state IDLE.
- Latency: last product accepted on edge N, out_valid high after edge N+1. Earliest next start is the cycle after the handshake completes.
- start is ignored in ACCUM, SAT and DONE; it is not queued.
- The accumulator never wraps internally given the ACC_WIDTH rule. Saturation happens only in SAT.
- KERNEL_SIZE=1: ACCUM lasts exactly one accepted beat.
- Reset asserted mid-window: partial sum is discarded immediately and all outputs take their reset values. No result is emitted.

Optional Feature:
- Macro: CONV_ACC_RELU_EN.
- Defined: in SAT, a negative saturated value is replaced by 0 before it is registered into out_data. out_data is never negative.
- Undefined: signed saturated value is passed unchanged. Activation is applied downstream.

Test Plan:
- Basic window: bias=100, start, 25 beats of in_data=16 back-to-back -> out_data=500, out_valid high one cycle after the 25th accepted beat.
- Positive saturation: bias=0, 25 beats of 256 (sum 6400) -> out_data=2047.
- Negative saturation: bias=-1000, 25 beats of -100 (sum -3500) -> out_data=-2048, or 0 with CONV_ACC_RELU_EN.
- Stalls and backpressure:
  - in_valid toggled 1/0 every cycle, 25 beats of 1, bias=-30 -> out_data=-5.
  - out_ready held low 5 cycles -> out_valid and out_data stay stable; returns to IDLE on the cycle after out_ready=1.
- start ignored: start pulsed during ACCUM and DONE -> no effect on cnt, acc or state; the result is unchanged.
- Reset mid-window: rst_n low after 10 beats -> outputs zero immediately. A fresh window of 25x4 with bias=0 then yields out_data=100.
